sine_addr_gen: RTL and testbench

//  Phase-accumulator address generator feeding the dual-port sine ROM.
//  - Advances a fixed-point phase each enabled cycle.
//  - Drives addr1 (phase) and addr2 (phase + offset), both used as ROM addresses.
//  - Frequency (increment) changes are glitch-free: each new increment is applied only at a phase wrap.
//  - Emits a wrap pulse and a valid flag aligned with the ROM's registered outputs.

---
 rtl/sine_addr_gen.sv | 106 ++++++++++
 tb/tb_sine_addr_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sine_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sine_addr_gen
//  Description : Phase-accumulator address generator for a dual-port sine ROM.
//                Produces a phase address and an offset phase address, a
//                wrap pulse, and a valid flag aligned with the ROM's
//                registered read data. Increment changes take effect only at
//                a phase wrap (or while idle) so the output frequency never
//                glitches mid-cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module sine_addr_gen #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int ACC_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [ACC_WIDTH-1:0]     incr_in,
    input  logic                     incr_ld,
    output logic                     incr_ack,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    output logic [ADDRESS_WIDTH-1:0] addr1,
    output logic [ADDRESS_WIDTH-1:0] addr2,
    output logic                     wrap,
    output logic                     rom_valid
);

    // Default increment steps the ROM address by exactly one per enabled cycle.
    localparam logic [ACC_WIDTH-1:0] c_DEFAULT_INCR =
        ACC_WIDTH'(1) << (ACC_WIDTH - ADDRESS_WIDTH);

    logic [ACC_WIDTH-1:0]     r_acc;
    logic [ACC_WIDTH-1:0]     r_active_incr;
    logic [ACC_WIDTH-1:0]     r_pend_incr;
    logic                     r_pending;
    logic [ADDRESS_WIDTH-1:0] r_offset_q;
    logic                     r_wrap;
    logic                     r_incr_ack;
    logic                     r_rom_valid;

    logic [ACC_WIDTH-1:0]     w_sum;
    logic                     w_carry;
    logic                     w_apply;

    // Widened add so the carry-out marks a phase wrap.
    assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, r_active_incr};

    // A pending increment is committed at a wrap, or at any idle edge since
    // there is no phase in progress to disturb.
    assign w_apply = r_pending && (!en || w_carry);

    // Phase accumulator and wrap pulse; the wrapping add uses the old increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_wrap <= 1'b0;
        end else if (en) begin
            r_acc  <= w_sum;
            r_wrap <= w_carry;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    // Increment handshake: capture on load strobe, promote to active on apply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active_incr <= c_DEFAULT_INCR;
            r_pend_incr   <= '0;
            r_pending     <= 1'b0;
            r_incr_ack    <= 1'b0;
        end else begin
            r_incr_ack <= w_apply;
            if (w_apply) begin
                r_active_incr <= r_pend_incr;
            end
            // A load on the apply edge re-arms pending with the new value.
            if (incr_ld) begin
                r_pend_incr <= incr_in;
                r_pending   <= 1'b1;
            end else if (w_apply) begin
                r_pending   <= 1'b0;
            end
        end
    end

    // Offset register and ROM-latency-matched valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_offset_q  <= '0;
            r_rom_valid <= 1'b0;
        end else begin
            r_offset_q  <= offset;
            r_rom_valid <= en;
        end
    end

    assign addr1     = r_acc[ACC_WIDTH-1 -: ADDRESS_WIDTH];
    assign addr2     = addr1 + r_offset_q;
    assign wrap      = r_wrap;
    assign incr_ack  = r_incr_ack;
    assign rom_valid = r_rom_valid;

endmodule
`default_nettype wire

// File: tb/tb_sine_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sine_addr_gen
//  Description : Directed self-checking bench for sine_addr_gen.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sine_addr_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] incr_in;
    logic        incr_ld;
    logic        incr_ack;
    logic [7:0]  offset;
    logic [7:0]  addr1;
    logic [7:0]  addr2;
    logic        wrap;
    logic        rom_valid;

    int total;
    int bad;
    int wraps;
    int acks;

    sine_addr_gen #(
        .ADDRESS_WIDTH (8),
        .ACC_WIDTH     (16)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .incr_in   (incr_in),
        .incr_ld   (incr_ld),
        .incr_ack  (incr_ack),
        .offset    (offset),
        .addr1     (addr1),
        .addr2     (addr2),
        .wrap      (wrap),
        .rom_valid (rom_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        en      = 1'b0;
        incr_in = '0;
        incr_ld = 1'b0;
        offset  = '0;

        // Reset state
        #12;
        check("rst_addr1", addr1, 0);
        check("rst_addr2", addr2, 0);
        check("rst_wrap", wrap, 0);
        check("rst_ack", incr_ack, 0);
        check("rst_valid", rom_valid, 0);

        // Default stepping: one address per cycle, valid one cycle after en
        rst_n = 1'b1;
        en    = 1'b1;
        check("t1_addr1_0", addr1, 0);
        tick();
        check("t1_addr1_1", addr1, 1);
        check("t1_valid", rom_valid, 1);
        tick();
        check("t1_addr1_2", addr1, 2);
        tick();
        check("t1_addr1_3", addr1, 3);

        // Wrap after 256 steps, single-cycle pulse
        wraps = 0;
        for (int i = 0; i < 252; i++) begin
            tick();
            if (wrap) wraps++;
        end
        check("t2_no_early_wrap", wraps, 0);
        check("t2_addr1_255", addr1, 255);
        tick();
        check("t2_addr1_0", addr1, 0);
        check("t2_wrap", wrap, 1);
        tick();
        check("t2_addr1_1", addr1, 1);
        check("t2_wrap_low", wrap, 0);

        // Increment change deferred to the next wrap
        for (int i = 0; i < 9; i++) tick();
        check("t3_addr1_10", addr1, 10);
        incr_in = 16'h0080;
        incr_ld = 1'b1;
        tick();
        incr_ld = 1'b0;
        check("t3_addr1_11", addr1, 11);
        acks = 0;
        for (int i = 0; i < 244; i++) begin
            tick();
            if (incr_ack) acks++;
        end
        check("t3_no_early_ack", acks, 0);
        check("t3_addr1_255", addr1, 255);
        tick();
        check("t3_wrap_addr1", addr1, 0);
        check("t3_wrap", wrap, 1);
        check("t3_ack", incr_ack, 1);
        tick();
        check("t3_half_a", addr1, 0);
        check("t3_ack_low", incr_ack, 0);
        tick();
        check("t3_half_b", addr1, 1);
        tick();
        check("t3_half_c", addr1, 1);
        tick();
        check("t3_half_d", addr1, 2);

        // Offset port with one-cycle lag and modular wrap
        offset = 8'd64;
        check("t4_addr2_lag", addr2, 2);
        tick();
        check("t4_addr2_66", addr2, 66);
        wraps = 0;
        for (int i = 0; i < 395; i++) begin
            tick();
            if (wrap) wraps++;
        end
        check("t4_no_wrap", wraps, 0);
        check("t4_addr1_200", addr1, 200);
        check("t4_addr2_8", addr2, 8);

        // Idle load applies on the following edge while phase holds
        en      = 1'b0;
        incr_in = 16'h0300;
        incr_ld = 1'b1;
        tick();
        incr_ld = 1'b0;
        check("t5_cap_ack", incr_ack, 0);
        check("t5_cap_hold", addr1, 200);
        check("t5_valid_low", rom_valid, 0);
        tick();
        check("t5_ack", incr_ack, 1);
        check("t5_hold", addr1, 200);
        en = 1'b1;
        tick();
        check("t5_step_a", addr1, 203);
        check("t5_ack_low", incr_ack, 0);
        tick();
        check("t5_step_b", addr1, 206);
        check("t5_addr2", addr2, 14);

        // Reset mid-run discards a pending increment
        incr_in = 16'h0500;
        incr_ld = 1'b1;
        tick();
        incr_ld = 1'b0;
        check("t6_pre", addr1, 209);
        rst_n = 1'b0;
        #1;
        check("t6_addr1", addr1, 0);
        check("t6_addr2", addr2, 0);
        check("t6_wrap", wrap, 0);
        check("t6_ack", incr_ack, 0);
        check("t6_valid", rom_valid, 0);
        rst_n = 1'b1;
        acks  = 0;
        tick();
        if (incr_ack) acks++;
        check("t6_step_1", addr1, 1);
        check("t6_addr2", addr2, 65);
        tick();
        if (incr_ack) acks++;
        check("t6_step_2", addr1, 2);
        tick();
        if (incr_ack) acks++;
        check("t6_step_3", addr1, 3);
        check("t6_no_ack", acks, 0);

        // Zero increment freezes phase and never wraps
        en      = 1'b0;
        incr_in = 16'h0000;
        incr_ld = 1'b1;
        tick();
        incr_ld = 1'b0;
        tick();
        check("t7_ack", incr_ack, 1);
        en = 1'b1;
        tick();
        check("t7_hold_a", addr1, 3);
        check("t7_wrap", wrap, 0);
        tick();
        check("t7_hold_b", addr1, 3);
        check("t7_valid", rom_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
